mul_add_seq: RTL and testbench

- Sequential shift-add multiply-accumulate computing product = multiplicand * multiplier + addend.
- Inverse of the team's combinational divider: it rebuilds dividend = quotient * divisor + remainder, and flags whether the triple is a legal divider output.
- Sits beside the divider as a self-check and reconstruction unit.
- Single-issue, fixed latency, start/busy/done handshake.

---
 rtl/mul_add_seq.sv | 140 ++++++++++++++
 tb/tb_mul_add_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mul_add_seq.sv
// mul_add_seq: sequential shift-add multiply-accumulate.
//
// Computes product = multiplicand * multiplier + addend by handling one multiplier bit
// per clock, LSB first. It rebuilds dividend = quotient * divisor + remainder for the
// combinational divider and flags whether the triple is a legal divider output.
// Latency is fixed at WIDTH+1 edges from the accepting edge, whatever the operand values.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request; sampled only when not busy (IDLE or DONE)
//   multiplicand divisor-side operand
//   multiplier   quotient-side operand
//   addend       remainder-side operand
//   busy         high while computing
//   done         one-cycle pulse when the result is valid
//   product      result, held until the next result is loaded
//   fits         product < 2^WIDTH and addend < multiplicand
//   zero_div     multiplicand == 0, latched when start is accepted
module mul_add_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     addend,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 fits,
    output logic                 zero_div
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  mcand_q;
    logic [WIDTH-1:0]  mult_q;
    logic [WIDTH-1:0]  addend_q;
    logic [PW-1:0]     acc_q;
    logic [CW-1:0]     count_q;
    logic [PW-1:0]     product_q;
    logic              fits_q;
    logic              zero_div_q;

    logic              accept;
    logic              last_bit;
    logic [PW-1:0]     partial;
    logic [PW-1:0]     acc_sum;

    // A request is taken in IDLE and also in DONE, which allows back-to-back operation.
    assign accept   = start && (state_q != StRun);
    assign last_bit = (count_q == CW'(WIDTH - 1));

    // Partial product for the current bit. The sum cannot overflow 2*WIDTH bits because
    // (2^W-1)^2 + (2^W-1) < 2^(2W).
    always_comb begin
        partial = '0;
        if (mult_q[0]) begin
            partial = {{WIDTH{1'b0}}, mcand_q} << count_q;
        end
        acc_sum = acc_q + partial;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (last_bit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = start ? StRun : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q    <= '0;
            mult_q     <= '0;
            addend_q   <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            product_q  <= '0;
            fits_q     <= 1'b0;
            zero_div_q <= 1'b0;
        end else if (accept) begin
            mcand_q    <= multiplicand;
            mult_q     <= multiplier;
            addend_q   <= addend;
            acc_q      <= {{WIDTH{1'b0}}, addend};
            count_q    <= '0;
            zero_div_q <= (multiplicand == '0);
        end else if (state_q == StRun) begin
            acc_q   <= acc_sum;
            mult_q  <= mult_q >> 1;
            count_q <= count_q + 1'b1;
            if (last_bit) begin
                // With a zero divisor addend < mcand is false, so fits is forced low.
                product_q <= acc_sum;
                fits_q    <= (acc_sum[PW-1:WIDTH] == '0) && (addend_q < mcand_q);
            end
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign product  = product_q;
    assign fits     = fits_q;
    assign zero_div = zero_div_q;

endmodule

// File: tb/tb_mul_add_seq.sv
// Directed and random self-checking bench for mul_add_seq (WIDTH = 8).
module tb_mul_add_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic [7:0]  addend;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        fits;
    logic        zero_div;

    int checks = 0;
    int errors = 0;

    mul_add_seq #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .fits         (fits),
        .zero_div     (zero_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one operation starting in the current cycle; returns the number of edges from
    // the accepting edge up to and including the edge that raises done, the count of busy
    // cycles and zero_div as seen right after acceptance. When lat reaches poke, a foreign
    // start with other operands is driven for one cycle.
    task automatic do_op(input int a, input int b, input int c, input int poke,
                         output int lat, output int busy_cycles, output int zd_early);
        multiplicand = 8'(a);
        multiplier   = 8'(b);
        addend       = 8'(c);
        start        = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        lat         = 1;
        busy_cycles = 0;
        zd_early    = int'(zero_div);
        check("accept_done_low", done, 0);
        if (busy) busy_cycles++;
        while (!done && lat < 40) begin
            if (lat == poke) begin
                start        = 1'b1;
                multiplicand = 8'd1;
                multiplier   = 8'd1;
                addend       = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cycles++;
        end
        start = 1'b0;
    endtask

    initial begin
        int lat, bc, zd, saw;
        int a, b, c, exp_p, exp_f;

        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        addend       = '0;

        // Reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        check("rst_fits", fits, 0);
        check("rst_zero_div", zero_div, 0);

        // Divider inverse 7*28+4
        do_op(7, 28, 4, 0, lat, bc, zd);
        check("inv_latency", lat, 9);
        check("inv_busy_cycles", bc, 8);
        check("inv_product", product, 200);
        check("inv_fits", fits, 1);
        check("inv_zero_div", zero_div, 0);
        @(posedge clk);
        #1;
        check("inv_done_one_cycle", done, 0);
        check("inv_idle_busy", busy, 0);
        check("inv_hold_product", product, 200);

        // Reset during RUN cycle 4: outputs clear at once, no done later
        multiplicand = 8'd255;
        multiplier   = 8'd255;
        addend       = 8'd255;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_product", product, 0);
        check("midrst_fits", fits, 0);
        check("midrst_zero_div", zero_div, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        saw = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) saw = 1;
        end
        check("midrst_no_done", saw, 0);

        // Extremes
        do_op(255, 255, 255, 0, lat, bc, zd);
        check("max_latency", lat, 9);
        check("max_product", product, 65280);
        check("max_fits", fits, 0);

        // Zero multiplier, back-to-back from DONE; addend 5 >= divisor 3 so not legal
        do_op(3, 0, 5, 0, lat, bc, zd);
        check("zmul_latency", lat, 9);
        check("zmul_product", product, 5);
        check("zmul_fits", fits, 0);

        do_op(7, 0, 5, 0, lat, bc, zd);
        check("zmul7_product", product, 5);
        check("zmul7_fits", fits, 1);

        // Divide-by-zero triple
        do_op(0, 0, 9, 0, lat, bc, zd);
        check("dz_early", zd, 1);
        check("dz_latency", lat, 9);
        check("dz_product", product, 9);
        check("dz_fits", fits, 0);
        check("dz_zero_div", zero_div, 1);

        // Start while busy is ignored
        do_op(7, 28, 4, 3, lat, bc, zd);
        check("ign_latency", lat, 9);
        check("ign_product", product, 200);
        check("ign_fits", fits, 1);
        check("ign_zero_div", zero_div, 0);

        // Back-to-back start in the DONE cycle
        do_op(12, 10, 3, 0, lat, bc, zd);
        check("b2b_latency", lat, 9);
        check("b2b_product", product, 123);
        check("b2b_fits", fits, 1);

        // Random operands with a divider round-trip for legal triples
        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            c = int'($urandom_range(0, 255));
            if (i % 4 == 0) b = int'($urandom_range(0, 3));
            if (i % 8 == 1 && a > 0) c = c % a;
            exp_p = a * b + c;
            exp_f = (exp_p < 256 && c < a) ? 1 : 0;
            do_op(a, b, c, 0, lat, bc, zd);
            check("rnd_latency", lat, 9);
            check("rnd_product", product, exp_p);
            check("rnd_fits", fits, exp_f);
            check("rnd_zero_div", zero_div, (a == 0) ? 1 : 0);
            if (fits && a != 0) begin
                check("rnd_quotient", int'(product) / a, b);
                check("rnd_remainder", int'(product) % a, c);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
